uart_fifo_ctrl: RTL
===================

Name: uart_fifo_ctrl

Overview:
Parametrised UART FIFO controller. It is the next generation of the fixed 8x16 syn_fifo plus the static interrupt AND-gates used in the UART IP. It adds programmable width and depth, an occupancy count, a threshold flag, sticky overrun/underrun flags, a receive-idle timeout, and a single registered masked interrupt. One instance sits on the Tx path and one on the Rx path, between the APB register file and UART_Tx/UART_Rx.

Parameters:
WIDTH, 8, data word width in bits.
DEPTH, 16, number of entries; power of two, at least 2. Localparam AW = log2(DEPTH).
TO_W, 16, width of the timeout counter and of to_limit.

Ports:
clk  in  1  system clock; all state is updated on the rising edge.
rst  in  1  asynchronous reset, active-high.
clr  in  1  synchronous flush pulse.
w_data  in  WIDTH  write data.
w_request  in  1  push request, one word per cycle when high.
r_request  in  1  pop request, one word per cycle when high.
r_data  out  WIDTH  head-of-FIFO data (first-word-fall-through).
thr_level  in  AW+1  threshold; 0 disables the threshold flag.
to_limit  in  TO_W  timeout limit in to_tick units; 0 disables the timeout.
to_tick  in  1  timeout time-base strobe (e.g. baud_clk), one clk wide.
irq_en  in  5  interrupt enables {timeout, underrun, overrun, thr, empty}.
level  out  AW+1  current number of stored words, 0..DEPTH.
full_status  out  1  level == DEPTH.
empty_status  out  1  level == 0.
thr_status  out  1  level >= thr_level, and thr_level != 0.
overrun  out  1  sticky flag: a write was dropped.
underrun  out  1  sticky flag: a read was made while empty.
timeout  out  1  sticky flag: FIFO non-empty and idle for to_limit ticks.
irq  out  1  registered OR of (irq_en & {timeout, underrun, overrun, thr_status, empty_status}).

Behaviour:
- Reset (rst=1, asynchronous): wr_ptr, rd_ptr, level, timeout counter, overrun, underrun, timeout and irq all clear to 0. empty_status=1, full_status=0, thr_status=0. r_data is don't-care while empty.
- Storage is DEPTH x WIDTH. Pointers are AW bits wide and wrap from DEPTH-1 to 0. level is tracked explicitly (AW+1 bits).
- r_data = mem[rd_ptr], read combinationally. A word written into an empty FIFO is visible on r_data the cycle after the write edge.
- Pop accepted (pop_ok) = r_request & !empty_status.
- Push accepted (push_ok) = w_request & (!full_status | pop_ok).
  - Full with simultaneous push and pop: both are accepted and level stays at DEPTH.
  - Empty with simultaneous push and pop: only the push is accepted, underrun sets, and level becomes 1.
- level next = level + push_ok - pop_ok. All status flags derive from the registered level, so they have 1-cycle latency after the causing edge.
- overrun sets on w_request & full_status & !pop_ok; the data is dropped. underrun sets on r_request & empty_status. Both hold until clr or rst.
- Timeout counter:
  - Cleared on push_ok, pop_ok, empty_status or to_limit==0.
  - Otherwise it increments on to_tick and saturates at to_limit.
  - timeout sets on the edge where the counter reaches to_limit.
  - timeout clears on pop_ok, clr or rst. A push alone does not clear it.
- irq is registered: it asserts 1 cycle after a flag it enables asserts, and deasserts 1 cycle after that flag clears or its enable drops.
- clr has priority over push and pop in the same cycle. It zeroes pointers, level, counter and all sticky flags. The push in that cycle is discarded and the memory contents are left as they are.
- Changing thr_level or to_limit mid-operation takes effect on the next compare. No other state is disturbed.
- rst asserted mid-transfer aborts immediately. Nothing stored is guaranteed after rst.

Test Plan:
1. DEPTH=16, WIDTH=8: push 0x00..0x0F on consecutive cycles, then 0x10 -> full_status=1, level=16, overrun=1, 0x10 dropped. 16 pops return 0x00..0x0F in order; empty_status=1.
2. Fill to 16, then push 0xAA and pop in the same cycle -> level stays 16, overrun=0. Drain: the last word read is 0xAA (pointer wrap verified).
3. Empty FIFO, push 0x55 and pop in the same cycle -> underrun=1, level=1, r_data=0x55 next cycle. Pulse clr -> underrun=0, level=0.
4. thr_level=4, irq_en=5'b00010: push 4 words -> thr_status=1 one cycle after the 4th push, irq=1 one cycle later. Pop 1 -> thr_status=0, then irq=0. Repeat with thr_level=0 -> thr_status never asserts.
5. to_limit=3, push 1 word then 3 to_tick pulses with no push/pop -> timeout=1 on the 3rd tick edge. Push another word -> timeout stays 1. Pop -> timeout=0. With to_limit=0, 100 ticks -> timeout stays 0.
6. Assert rst mid-burst at level=7 -> all outputs take reset values asynchronously (level=0, empty_status=1, irq=0). After release, a push of 0x3C is read back correctly.

Source files
------------

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl
//   Parametrised first-word-fall-through FIFO for the UART Tx/Rx paths, with
//   occupancy level, threshold flag, sticky overrun/underrun flags, receive
//   idle timeout and one registered, masked interrupt.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   clr           synchronous flush (pointers, level, counter, sticky flags)
//   w_data/w_request   push side, one word per cycle
//   r_request/r_data   pop side, r_data shows the head word combinationally
//   thr_level     threshold for thr_status (0 disables)
//   to_limit      idle timeout in to_tick units (0 disables)
//   to_tick       timeout time-base strobe
//   irq_en        enables {timeout, underrun, overrun, thr, empty}
//   level, full_status, empty_status, thr_status   occupancy status
//   overrun, underrun, timeout                     sticky error/event flags
//   irq           registered OR of the enabled sources
module uart_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int TO_W  = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] w_data,
    input  logic             w_request,
    input  logic             r_request,
    output logic [WIDTH-1:0] r_data,
    input  logic [AW:0]      thr_level,
    input  logic [TO_W-1:0]  to_limit,
    input  logic             to_tick,
    input  logic [4:0]       irq_en,
    output logic [AW:0]      level,
    output logic             full_status,
    output logic             empty_status,
    output logic             thr_status,
    output logic             overrun,
    output logic             underrun,
    output logic             timeout,
    output logic             irq
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_cnt_inc;
    logic             pop_ok, push_ok;
    logic             to_hold;
    logic [4:0]       irq_src;

    // Status is decoded from the registered level only.
    assign empty_status = (level == '0);
    assign full_status  = (level == (AW+1)'(DEPTH));
    assign thr_status   = (thr_level != '0) && (level >= thr_level);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts
    // a push that is paired with a pop.
    assign pop_ok  = r_request & ~empty_status;
    assign push_ok = w_request & (~full_status | pop_ok);

    assign r_data = mem[rd_ptr];

    // Any traffic, an empty FIFO or a disabled limit keeps the counter at 0.
    assign to_hold    = push_ok | pop_ok | empty_status | (to_limit == '0);
    assign to_cnt_inc = to_cnt + TO_W'(1);

    assign irq_src = {timeout, underrun, overrun, thr_status, empty_status};

    // Storage is not reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_ok && !clr)
            mem[wr_ptr] <= w_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            to_cnt   <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
            timeout  <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            to_cnt   <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            // Pointers are AW bits, so DEPTH-1 wraps to 0 naturally.
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);

            case ({push_ok, pop_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase

            if (w_request && full_status && !pop_ok) overrun  <= 1'b1;
            if (r_request && empty_status)           underrun <= 1'b1;

            if (to_hold)
                to_cnt <= '0;
            else if (to_tick && (to_cnt < to_limit))
                to_cnt <= to_cnt_inc;

            // A push restarts the idle count but leaves a raised timeout;
            // only reading the data acknowledges it.
            if (pop_ok)
                timeout <= 1'b0;
            else if (!to_hold && to_tick && (to_cnt < to_limit) &&
                     (to_cnt_inc == to_limit))
                timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= |(irq_en & irq_src);
    end

endmodule
